// File: rtl/aes_pkg.sv
// aes_pkg: FSM state encoding, Rcon and GF(2^8) byte helpers shared by the AES-128 inverse cipher.
package aes_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        KEY_EXP  = 4'd1,
        INIT_ARK = 4'd2,
        ROUND    = 4'd3,
        FINAL    = 4'd4,
        DONE     = 4'd5
    } state_t;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        return r == 4'd9 ? 8'h1b :
               r == 4'd10 ? 8'h36 :
               (r >= 4'd1 && r <= 4'd8) ? 8'(32'd1 << (r - 4'd1)) : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), avoiding stored S-box tables.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] r;
        t = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, forward (K[i-1] -> K[i]) or inverse (K[i] -> K[i-1]).
module aes_key_step (
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    input  logic         dir,
    output logic [127:0] next_key
);
    import aes_pkg::*;

    logic [31:0] w0, w1, w2, w3, iw3, rw, sw, f0, f1, f2;

    // Both directions share one SubWord: forward uses w3, inverse uses the recovered w3 of K[i-1].
    always_comb begin
        {w0, w1, w2, w3} = key;
        iw3 = w3 ^ w2;
        rw = dir ? {iw3[23:0], iw3[31:24]} : {w3[23:0], w3[31:24]};
        sw = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ {rcon, 24'h0};
        f0 = w0 ^ sw;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        next_key = dir ? {f0, w1 ^ w0, w2 ^ w1, iw3} : {f0, f1, f2, w3 ^ f2};
    end

endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher, one round per clock, round keys regenerated backwards.
// Optional AES_DEC_KEY_CACHE_EN: remembers K10 of the last key so a repeated key skips expansion.
module aes_decrypt #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cyphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy,
    output logic [3:0]   state_check
);
    import aes_pkg::*;

    state_t       state;
    logic [3:0]   rnd;
    logic [127:0] data, kreg;
    logic [127:0] sub_out, round_out, step_out, k10_cache;
    logic [7:0]   rcon_sel;
    logic         hit;

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = inv_sbox(s[127-32*((c-r+4)%4)-8*r -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    assign sub_out   = inv_shift_sub(data);
    assign round_out = inv_mix(sub_out ^ kreg);
    assign rcon_sel  = rcon_of(state == INIT_ARK ? 4'(NR) : rnd);

    aes_key_step u_step (
        .key      (kreg),
        .rcon     (rcon_sel),
        .dir      (state != KEY_EXP),
        .next_key (step_out)
    );

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] tag;
    logic         valid;

    assign hit = valid && key == tag;

    // Tag is taken at acceptance since the key input may change during expansion; valid rises once K10 exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k10_cache <= '0;
            tag       <= '0;
            valid     <= 1'b0;
        end else if (state == IDLE && start && !hit) begin
            tag   <= key;
            valid <= 1'b0;
        end else if (state == KEY_EXP && rnd == 4'(NR)) begin
            k10_cache <= step_out;
            valid     <= 1'b1;
        end
    end
`else
    assign hit       = 1'b0;
    assign k10_cache = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= '0;
            data      <= '0;
            kreg      <= '0;
            plaintext <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    data  <= cyphertext;
                    kreg  <= hit ? k10_cache : key;
                    rnd   <= 4'd1;
                    state <= hit ? INIT_ARK : KEY_EXP;
                end
                KEY_EXP: begin
                    kreg <= step_out;
                    rnd  <= rnd + 4'd1;
                    if (rnd == 4'(NR)) state <= INIT_ARK;
                end
                INIT_ARK: begin
                    data  <= data ^ kreg;
                    kreg  <= step_out;
                    rnd   <= 4'(NR - 1);
                    state <= ROUND;
                end
                ROUND: begin
                    data <= round_out;
                    kreg <= step_out;
                    rnd  <= rnd - 4'd1;
                    if (rnd == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    plaintext <= sub_out ^ kreg;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_check = state;
    assign busy        = state != IDLE;
    assign done        = state == DONE;

endmodule
